// File: rtl/display_link_sequencer.sv
// display_link_sequencer
//   Brings up a three-channel TMDS link in the pixel-clock domain.
//   The sequence is:
//   1. Wait for a stable clock-generator lock.
//   2. Hold the serializers in reset for a fixed interval.
//   3. Send CTRL tokens for a training interval.
//   4. Pass encoder words through.
//   Any loss of the synchronized lock drops the link back to RESET.
//
// Optional build macro:
//   LINK_PATTERN_EN - adds i_pattern. While ACTIVE with i_pattern=1, every
//                     channel carries an alternating 10'h155 / 10'h2AA
//                     clock-like pattern instead of encoder data.
//
// Ports:
//   i_clk         pixel clock (serializer parallel clock)
//   i_rst         asynchronous active-high reset
//   i_clk_lock    clock-generator lock, asynchronous (synchronized here)
//   i_de          data enable aligned with i_tmds_*
//   i_pattern     pattern select (LINK_PATTERN_EN builds only)
//   i_tmds_ch0..2 encoded 10-bit words from the encoder
//   o_ser_rst     active-high reset to all three serializers
//   o_tmds_ch0..2 words to the serializers
//   o_link_up     high only in ACTIVE
//   o_state       current state encoding (debug)
module display_link_sequencer #(
    parameter int LOCK_CYCLES    = 1024,
    parameter int SER_RST_CYCLES = 16,
    parameter int CTRL_CYCLES    = 256
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clk_lock,
    input  logic       i_de,
`ifdef LINK_PATTERN_EN
    input  logic       i_pattern,
`endif
    input  logic [9:0] i_tmds_ch0,
    input  logic [9:0] i_tmds_ch1,
    input  logic [9:0] i_tmds_ch2,
    output logic       o_ser_rst,
    output logic [9:0] o_tmds_ch0,
    output logic [9:0] o_tmds_ch1,
    output logic [9:0] o_tmds_ch2,
    output logic       o_link_up,
    output logic [2:0] o_state
);

    localparam int MAX_AB  = (LOCK_CYCLES > SER_RST_CYCLES) ? LOCK_CYCLES : SER_RST_CYCLES;
    localparam int MAX_CYC = (MAX_AB > CTRL_CYCLES) ? MAX_AB : CTRL_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SER_LAST  = CNT_W'(SER_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(CTRL_CYCLES - 1);

    // CTRL token with C1C0 = 00
    localparam logic [9:0] CTRL_TOKEN = 10'b1101010100;
`ifdef LINK_PATTERN_EN
    localparam logic [9:0] PAT_EVEN = 10'b0101010101;
    localparam logic [9:0] PAT_ODD  = 10'b1010101010;
`endif

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_SER_RST   = 3'd2,
        ST_CTRL      = 3'd3,
        ST_ACTIVE    = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             lock_meta_p0, lock_s_p1;
    logic [9:0]       tmds0_nx, tmds1_nx, tmds2_nx;

    // ---- stage p0/p1: two-flop lock synchronizer ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_meta_p0 <= 1'b0;
            lock_s_p1    <= 1'b0;
        end else begin
            lock_meta_p0 <= i_clk_lock;
            lock_s_p1    <= lock_meta_p0;
        end
    end

    // Next-state and shared counter; the counter clears on every state change.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_RESET: begin
                state_nx = ST_LOCK_WAIT;
                cnt_nx   = '0;
            end
            ST_LOCK_WAIT: begin
                if (!lock_s_p1) begin
                    cnt_nx = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nx = ST_SER_RST;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_SER_RST: begin
                if (!lock_s_p1) begin
                    state_nx = ST_RESET;
                    cnt_nx   = '0;
                end else if (cnt == SER_LAST) begin
                    state_nx = ST_CTRL;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_CTRL: begin
                // Counter saturates; the exit waits for a blanking cycle so
                // ACTIVE never starts in the middle of a line.
                if (!lock_s_p1) begin
                    state_nx = ST_RESET;
                    cnt_nx   = '0;
                end else if (cnt == CTRL_LAST) begin
                    if (!i_de) begin
                        state_nx = ST_ACTIVE;
                        cnt_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!lock_s_p1) begin
                    state_nx = ST_RESET;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_RESET;
                cnt_nx   = '0;
            end
        endcase
    end

`ifdef LINK_PATTERN_EN
    // pat_odd holds the parity of the next ACTIVE cycle; it is forced to
    // even on ACTIVE entry because it is cleared whenever we are not ACTIVE.
    logic pat_odd;
    logic pat_phase;
    assign pat_phase = (state == ST_ACTIVE) ? pat_odd : 1'b0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pat_odd <= 1'b0;
        end else begin
            pat_odd <= (state_nx == ST_ACTIVE) ? ~pat_phase : 1'b0;
        end
    end
`endif

    // Output words are decoded from the next state so they change on the
    // same edge as o_state.
    always_comb begin
        tmds0_nx = CTRL_TOKEN;
        tmds1_nx = CTRL_TOKEN;
        tmds2_nx = CTRL_TOKEN;
        if (state_nx == ST_ACTIVE) begin
            tmds0_nx = i_tmds_ch0;
            tmds1_nx = i_tmds_ch1;
            tmds2_nx = i_tmds_ch2;
`ifdef LINK_PATTERN_EN
            if (i_pattern) begin
                tmds0_nx = pat_phase ? PAT_ODD : PAT_EVEN;
                tmds1_nx = pat_phase ? PAT_ODD : PAT_EVEN;
                tmds2_nx = pat_phase ? PAT_ODD : PAT_EVEN;
            end
`endif
        end
    end

    // ---- stage p2: state, counter and registered outputs ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_RESET;
            cnt        <= '0;
            o_ser_rst  <= 1'b1;
            o_link_up  <= 1'b0;
            o_tmds_ch0 <= CTRL_TOKEN;
            o_tmds_ch1 <= CTRL_TOKEN;
            o_tmds_ch2 <= CTRL_TOKEN;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            o_ser_rst  <= (state_nx != ST_CTRL) && (state_nx != ST_ACTIVE);
            o_link_up  <= (state_nx == ST_ACTIVE);
            o_tmds_ch0 <= tmds0_nx;
            o_tmds_ch1 <= tmds1_nx;
            o_tmds_ch2 <= tmds2_nx;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_display_link_sequencer.sv
// Testbench for display_link_sequencer (LOCK=8, SER_RST=4, CTRL=6).
// Directed table rows, hand-written corner sequences and a randomized
// run, all checked against a time-in-stage reference model.
module tb_display_link_sequencer;

    localparam int LOCK = 8;
    localparam int SR   = 4;
    localparam int CC   = 6;
    localparam logic [9:0] TOKEN = 10'b1101010100;
`ifdef LINK_PATTERN_EN
    localparam bit PAT_ON = 1'b1;
`else
    localparam bit PAT_ON = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_clk_lock = 1'b0;
    logic       i_de = 1'b0;
    logic [9:0] i_tmds_ch0 = '0, i_tmds_ch1 = '0, i_tmds_ch2 = '0;
    logic       o_ser_rst, o_link_up;
    logic [9:0] o_tmds_ch0, o_tmds_ch1, o_tmds_ch2;
    logic [2:0] o_state;
`ifdef LINK_PATTERN_EN
    logic       i_pattern = 1'b0;
`endif
    bit         cur_pat = 1'b0;

    display_link_sequencer #(
        .LOCK_CYCLES(LOCK), .SER_RST_CYCLES(SR), .CTRL_CYCLES(CC)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_lock(i_clk_lock), .i_de(i_de),
`ifdef LINK_PATTERN_EN
        .i_pattern(i_pattern),
`endif
        .i_tmds_ch0(i_tmds_ch0), .i_tmds_ch1(i_tmds_ch1), .i_tmds_ch2(i_tmds_ch2),
        .o_ser_rst(o_ser_rst), .o_tmds_ch0(o_tmds_ch0), .o_tmds_ch1(o_tmds_ch1),
        .o_tmds_ch2(o_tmds_ch2), .o_link_up(o_link_up), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: stage number, time spent in the stage, and a
    // two-deep delay line for the lock input.
    bit         sq0, sq1;
    int         m_stage, m_t, m_k;
    logic [9:0] m_d0, m_d1, m_d2;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sq0 = 0; sq1 = 0; m_stage = 0; m_t = 0; m_k = 0;
        m_d0 = TOKEN; m_d1 = TOKEN; m_d2 = TOKEN;
    endtask

    task automatic model_edge();
        bit ls;
        int prev;
        ls   = sq1;
        sq1  = sq0;
        sq0  = i_clk_lock;
        prev = m_stage;
        case (m_stage)
            0: begin m_stage = 1; m_t = 0; end
            1: if (!ls) m_t = 0;
               else if (m_t + 1 == LOCK) begin m_stage = 2; m_t = 0; end
               else m_t++;
            2: if (!ls) begin m_stage = 0; m_t = 0; end
               else if (m_t + 1 == SR) begin m_stage = 3; m_t = 0; end
               else m_t++;
            3: if (!ls) begin m_stage = 0; m_t = 0; end
               else if (m_t + 1 >= CC && !i_de) begin m_stage = 4; m_t = 0; end
               else m_t++;
            default: if (!ls) begin m_stage = 0; m_t = 0; end
        endcase
        if (m_stage == 4) begin
            m_k = (prev == 4) ? m_k + 1 : 0;
            if (cur_pat) begin
                m_d0 = (m_k % 2 == 1) ? 10'h2AA : 10'h155;
                m_d1 = m_d0; m_d2 = m_d0;
            end else begin
                m_d0 = i_tmds_ch0; m_d1 = i_tmds_ch1; m_d2 = i_tmds_ch2;
            end
        end else begin
            m_k = 0;
            m_d0 = TOKEN; m_d1 = TOKEN; m_d2 = TOKEN;
        end
    endtask

    task automatic model_check();
        chk("m_state", 32'(o_state), 32'(m_stage));
        chk("m_ser_rst", 32'(o_ser_rst), 32'(m_stage < 3));
        chk("m_link_up", 32'(o_link_up), 32'(m_stage == 4));
        chk("m_ch0", 32'(o_tmds_ch0), 32'(m_d0));
        chk("m_ch1", 32'(o_tmds_ch1), 32'(m_d1));
        chk("m_ch2", 32'(o_tmds_ch2), 32'(m_d2));
    endtask

    task automatic step(bit rst, bit lock, bit de, logic [9:0] a, logic [9:0] b,
                        logic [9:0] c, bit pat);
        @(negedge i_clk);
        i_rst = rst; i_clk_lock = lock; i_de = de;
        i_tmds_ch0 = a; i_tmds_ch1 = b; i_tmds_ch2 = c;
        cur_pat = pat & PAT_ON;
`ifdef LINK_PATTERN_EN
        i_pattern = cur_pat;
`endif
        if (rst) model_reset();
        @(posedge i_clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        int         n;
        bit         rst, lock, de;
        logic [9:0] d0, d1, d2;
        logic [2:0] st;
        bit         sr, lu;
        logic [9:0] e0, e1, e2;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [9:0] rv0, rv1, rv2;
        bit lk, de, pt, rs;

        model_reset();

        // n, rst, lock, de, data in, state, ser_rst, link_up, data out
        tbl.push_back('{1,  1, 0, 0, 10'h111, 10'h222, 10'h333, 3'd0, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{50, 0, 0, 0, 10'h111, 10'h222, 10'h333, 3'd1, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{9,  0, 1, 0, 10'h0F0, 10'h00F, 10'h3C3, 3'd1, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{1,  0, 1, 0, 10'h0F0, 10'h00F, 10'h3C3, 3'd2, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{3,  0, 1, 0, 10'h0F0, 10'h00F, 10'h3C3, 3'd2, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{1,  0, 1, 0, 10'h0F0, 10'h00F, 10'h3C3, 3'd3, 0, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{5,  0, 1, 0, 10'h123, 10'h321, 10'h231, 3'd3, 0, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{1,  0, 1, 0, 10'h2AB, 10'h155, 10'h3FF, 3'd4, 0, 1, 10'h2AB, 10'h155, 10'h3FF});
        tbl.push_back('{1,  0, 0, 0, 10'h001, 10'h002, 10'h003, 3'd4, 0, 1, 10'h001, 10'h002, 10'h003});
        tbl.push_back('{1,  0, 0, 0, 10'h004, 10'h005, 10'h006, 3'd4, 0, 1, 10'h004, 10'h005, 10'h006});
        tbl.push_back('{1,  0, 0, 0, 10'h007, 10'h008, 10'h009, 3'd0, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{1,  0, 0, 0, 10'h007, 10'h008, 10'h009, 3'd1, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{5,  0, 1, 0, 10'h007, 10'h008, 10'h009, 3'd1, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{3,  0, 0, 0, 10'h007, 10'h008, 10'h009, 3'd1, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{9,  0, 1, 0, 10'h007, 10'h008, 10'h009, 3'd1, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{1,  0, 1, 0, 10'h007, 10'h008, 10'h009, 3'd2, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{3,  0, 1, 0, 10'h007, 10'h008, 10'h009, 3'd2, 1, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{1,  0, 1, 0, 10'h007, 10'h008, 10'h009, 3'd3, 0, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{20, 0, 1, 1, 10'h0AA, 10'h0BB, 10'h0CC, 3'd3, 0, 0, TOKEN, TOKEN, TOKEN});
        tbl.push_back('{1,  0, 1, 0, 10'h3AB, 10'h1CD, 10'h2EF, 3'd4, 0, 1, 10'h3AB, 10'h1CD, 10'h2EF});
        tbl.push_back('{1,  1, 1, 0, 10'h3AB, 10'h1CD, 10'h2EF, 3'd0, 1, 0, TOKEN, TOKEN, TOKEN});

        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].n; k++)
                step(tbl[r].rst, tbl[r].lock, tbl[r].de, tbl[r].d0, tbl[r].d1, tbl[r].d2, 1'b0);
            chk($sformatf("tbl_state[%0d]", r), 32'(o_state), 32'(tbl[r].st));
            chk($sformatf("tbl_ser_rst[%0d]", r), 32'(o_ser_rst), 32'(tbl[r].sr));
            chk($sformatf("tbl_link_up[%0d]", r), 32'(o_link_up), 32'(tbl[r].lu));
            chk($sformatf("tbl_ch0[%0d]", r), 32'(o_tmds_ch0), 32'(tbl[r].e0));
            chk($sformatf("tbl_ch1[%0d]", r), 32'(o_tmds_ch1), 32'(tbl[r].e1));
            chk($sformatf("tbl_ch2[%0d]", r), 32'(o_tmds_ch2), 32'(tbl[r].e2));
        end

        // Bring-up to ACTIVE, optional pattern, then async reset mid-cycle.
        step(1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 1'b0);
        for (int k = 0; k < 19; k++)
            step(1'b0, 1'b1, 1'b0, 10'h0, 10'h0, 10'h0, 1'b0);
        chk("seq_pre_active", 32'(o_state), 32'd3);
        for (int k = 0; k < 4; k++) begin
            logic [9:0] exp;
            step(1'b0, 1'b1, 1'b0, 10'h05A, 10'h05A, 10'h05A, 1'b1);
            exp = PAT_ON ? ((k % 2 == 1) ? 10'h2AA : 10'h155) : 10'h05A;
            chk($sformatf("seq_pat_ch0[%0d]", k), 32'(o_tmds_ch0), 32'(exp));
            chk($sformatf("seq_pat_ch2[%0d]", k), 32'(o_tmds_ch2), 32'(exp));
        end
        step(1'b0, 1'b1, 1'b0, 10'h0F0, 10'h10F, 10'h2F0, 1'b0);
        chk("seq_resume_ch0", 32'(o_tmds_ch0), 32'h0F0);
        chk("seq_resume_ch1", 32'(o_tmds_ch1), 32'h10F);

        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        chk("async_state", 32'(o_state), 32'd0);
        chk("async_ser_rst", 32'(o_ser_rst), 32'd1);
        chk("async_link_up", 32'(o_link_up), 32'd0);
        chk("async_ch1", 32'(o_tmds_ch1), 32'(TOKEN));
        step(1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 1'b0);

        // Randomized run: long lock runs, bursty DE, rare resets.
        lk = 1'b1; de = 1'b0; pt = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 63) == 0) lk = ~lk;
            if ($urandom_range(0, 7) == 0) de = ~de;
            if ($urandom_range(0, 15) == 0) pt = ~pt;
            rs  = ($urandom_range(0, 799) == 0);
            rv0 = 10'($urandom);
            rv1 = 10'($urandom);
            rv2 = 10'($urandom);
            step(rs, lk, de, rv0, rv1, rv2, pt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
